// File: rtl/rv_opfetch_if.sv
// ============================================================================
// Module : rv_opfetch_if
// Brief  : Decode/regfile/bypass/execute signal bundle for rv_opfetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rv_opfetch_if #(
    parameter int CTRL_W = 16
);
    // decode side
    logic              i_flush;
    logic              i_valid;
    logic              o_ready;
    logic [31:0]       i_pc;
    logic [4:0]        i_rs1;
    logic [4:0]        i_rs2;
    logic [4:0]        i_rd;
    logic [CTRL_W-1:0] i_ctrl;
    // register file read port
    logic              o_rs_valid;
    logic [4:0]        o_rs1;
    logic [4:0]        o_rs2;
    logic [31:0]       i_rdata1;
    logic [31:0]       i_rdata2;
    // bypass sources
    logic              i_ex_valid;
    logic              i_ex_load;
    logic [4:0]        i_ex_rd;
    logic [31:0]       i_ex_data;
    logic              i_wb_write;
    logic [4:0]        i_wb_rd;
    logic [31:0]       i_wb_data;
    // execute side
    logic              o_valid;
    logic              i_ready;
    logic [31:0]       o_pc;
    logic [4:0]        o_rd;
    logic [CTRL_W-1:0] o_ctrl;
    logic [31:0]       o_op1;
    logic [31:0]       o_op2;

    modport slave (
        input  i_flush, i_valid, i_pc, i_rs1, i_rs2, i_rd, i_ctrl,
        input  i_rdata1, i_rdata2,
        input  i_ex_valid, i_ex_load, i_ex_rd, i_ex_data,
        input  i_wb_write, i_wb_rd, i_wb_data,
        input  i_ready,
        output o_ready, o_rs_valid, o_rs1, o_rs2,
        output o_valid, o_pc, o_rd, o_ctrl, o_op1, o_op2
    );

    modport master (
        output i_flush, i_valid, i_pc, i_rs1, i_rs2, i_rd, i_ctrl,
        output i_rdata1, i_rdata2,
        output i_ex_valid, i_ex_load, i_ex_rd, i_ex_data,
        output i_wb_write, i_wb_rd, i_wb_data,
        output i_ready,
        input  o_ready, o_rs_valid, o_rs1, o_rs2,
        input  o_valid, o_pc, o_rd, o_ctrl, o_op1, o_op2
    );
endinterface

`default_nettype wire

// File: rtl/rv_opfetch.sv
// ============================================================================
// Module : rv_opfetch
// Brief  : Single-slot operand-fetch stage with EX/WB bypass, regfile
//          write-gap cover and load-use stall.
//          Define RV_OPFETCH_FWD_EX_EN to enable the EX-result bypass path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rv_opfetch #(
    parameter int CTRL_W = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    rv_opfetch_if.slave bus
);

    localparam logic [4:0] c_x0 = 5'd0;

    // S1 slot
    logic              s1_valid_q, s1_valid_d;
    logic [31:0]       s1_pc_q,    s1_pc_d;
    logic [4:0]        s1_rs1_q,   s1_rs1_d;
    logic [4:0]        s1_rs2_q,   s1_rs2_d;
    logic [4:0]        s1_rd_q,    s1_rd_d;
    logic [CTRL_W-1:0] s1_ctrl_q,  s1_ctrl_d;

    // one-cycle-old WB write, covering the regfile write-to-read gap
    logic              wb_write_q, wb_write_d;
    logic [4:0]        wb_rd_q,    wb_rd_d;
    logic [31:0]       wb_data_q,  wb_data_d;

    logic        w_hazard;
    logic        w_ex_blocks;
    logic        w_ex_fwd;
    logic        w_ready;
    logic        w_valid;
    logic        w_accept;
    logic        w_drain;
    logic [31:0] w_op1;
    logic [31:0] w_op2;

    function automatic logic [31:0] resolve(
        input logic [4:0]  rs,
        input logic [31:0] rdata,
        input logic        ex_fwd,
        input logic [4:0]  ex_rd,
        input logic [31:0] ex_data,
        input logic        wb_write,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_data,
        input logic        dwb_write,
        input logic [4:0]  dwb_rd,
        input logic [31:0] dwb_data
    );
        logic [31:0] v;
        if (rs == c_x0) begin
            v = 32'd0;
        end else if (ex_fwd && (ex_rd == rs)) begin
            v = ex_data;
        end else if (wb_write && (wb_rd == rs)) begin
            v = wb_data;
        end else if (dwb_write && (dwb_rd == rs)) begin
            v = dwb_data;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

`ifdef RV_OPFETCH_FWD_EX_EN
    // only loads stall; ALU results are bypassed from EX
    assign w_ex_blocks = bus.i_ex_load;
    assign w_ex_fwd    = bus.i_ex_valid & ~bus.i_ex_load;
`else
    // no EX bypass: any pending EX write to a source must wait for WB
    assign w_ex_blocks = 1'b1;
    assign w_ex_fwd    = 1'b0;
`endif

    always_comb begin
        w_hazard = s1_valid_q & bus.i_ex_valid & w_ex_blocks
                 & (bus.i_ex_rd != c_x0)
                 & ((bus.i_ex_rd == s1_rs1_q) | (bus.i_ex_rd == s1_rs2_q));
        w_valid  = s1_valid_q & ~w_hazard & ~bus.i_flush;
        w_ready  = ~bus.i_flush & (~s1_valid_q | (bus.i_ready & ~w_hazard));
        w_accept = bus.i_valid & w_ready;
        w_drain  = bus.i_ready & w_valid;
    end

    always_comb begin
        w_op1 = resolve(s1_rs1_q, bus.i_rdata1, w_ex_fwd, bus.i_ex_rd, bus.i_ex_data,
                        bus.i_wb_write, bus.i_wb_rd, bus.i_wb_data,
                        wb_write_q, wb_rd_q, wb_data_q);
        w_op2 = resolve(s1_rs2_q, bus.i_rdata2, w_ex_fwd, bus.i_ex_rd, bus.i_ex_data,
                        bus.i_wb_write, bus.i_wb_rd, bus.i_wb_data,
                        wb_write_q, wb_rd_q, wb_data_q);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_pc_d    = s1_pc_q;
        s1_rs1_d   = s1_rs1_q;
        s1_rs2_d   = s1_rs2_q;
        s1_rd_d    = s1_rd_q;
        s1_ctrl_d  = s1_ctrl_q;
        wb_write_d = bus.i_wb_write;
        wb_rd_d    = bus.i_wb_rd;
        wb_data_d  = bus.i_wb_data;

        // flush already forces w_accept low through w_ready
        if (bus.i_flush) begin
            s1_valid_d = 1'b0;
        end else if (w_accept) begin
            s1_valid_d = 1'b1;
            s1_pc_d    = bus.i_pc;
            s1_rs1_d   = bus.i_rs1;
            s1_rs2_d   = bus.i_rs2;
            s1_rd_d    = bus.i_rd;
            s1_ctrl_d  = bus.i_ctrl;
        end else if (w_drain) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_valid_q <= 1'b0;
            s1_pc_q    <= 32'd0;
            s1_rs1_q   <= 5'd0;
            s1_rs2_q   <= 5'd0;
            s1_rd_q    <= 5'd0;
            s1_ctrl_q  <= '0;
            wb_write_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_pc_q    <= s1_pc_d;
            s1_rs1_q   <= s1_rs1_d;
            s1_rs2_q   <= s1_rs2_d;
            s1_rd_q    <= s1_rd_d;
            s1_ctrl_q  <= s1_ctrl_d;
            wb_write_q <= wb_write_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // read addresses go straight through; the regfile latches them on o_rs_valid
    assign bus.o_rs_valid = w_accept;
    assign bus.o_rs1      = bus.i_rs1;
    assign bus.o_rs2      = bus.i_rs2;
    assign bus.o_ready    = w_ready;
    assign bus.o_valid    = w_valid;
    assign bus.o_pc       = s1_pc_q;
    assign bus.o_rd       = s1_rd_q;
    assign bus.o_ctrl     = s1_ctrl_q;
    assign bus.o_op1      = w_op1;
    assign bus.o_op2      = w_op2;

endmodule

`default_nettype wire

// File: tb/tb_rv_opfetch.sv
// ============================================================================
// Module : tb_rv_opfetch
// Brief  : Self-checking bench for rv_opfetch with a latency-accurate regfile.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rv_opfetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv_opfetch_if #(.CTRL_W(16)) bus ();

    rv_opfetch #(.CTRL_W(16)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // register file: addresses latched on o_rs_valid, data registered every cycle
    logic [31:0] rf [32];
    logic [4:0]  ra1, ra2;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
            ra1 <= 5'd0; ra2 <= 5'd0;
            bus.i_rdata1 <= 32'd0; bus.i_rdata2 <= 32'd0;
        end else begin
            if (bus.o_rs_valid) begin
                ra1 <= bus.o_rs1; ra2 <= bus.o_rs2;
                bus.i_rdata1 <= rf[bus.o_rs1]; bus.i_rdata2 <= rf[bus.o_rs2];
            end else begin
                bus.i_rdata1 <= rf[ra1]; bus.i_rdata2 <= rf[ra2];
            end
            if (bus.i_wb_write) rf[bus.i_wb_rd] <= bus.i_wb_data;
        end
    end

    // reference model: operands are the architectural register values right now
    logic        m_v;
    logic [31:0] m_pc;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [15:0] m_ctrl;

`ifdef RV_OPFETCH_FWD_EX_EN
    wire ex_blocks = bus.i_ex_load;
    wire ex_fwd    = bus.i_ex_valid & ~bus.i_ex_load;
`else
    wire ex_blocks = 1'b1;
    wire ex_fwd    = 1'b0;
`endif
    wire exp_hz    = m_v & bus.i_ex_valid & ex_blocks & (bus.i_ex_rd != 5'd0)
                   & ((bus.i_ex_rd == m_rs1) | (bus.i_ex_rd == m_rs2));
    wire exp_valid = m_v & ~exp_hz & ~bus.i_flush;
    wire exp_ready = ~bus.i_flush & (~m_v | (bus.i_ready & ~exp_hz));

    function automatic logic [31:0] want_op(input logic [4:0] rs);
        if (rs == 5'd0) return 32'd0;
        if (ex_fwd && bus.i_ex_rd == rs) return bus.i_ex_data;
        if (bus.i_wb_write && bus.i_wb_rd == rs) return bus.i_wb_data;
        return rf[rs];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v <= 1'b0; m_pc <= 32'd0; m_rs1 <= 5'd0; m_rs2 <= 5'd0;
            m_rd <= 5'd0; m_ctrl <= 16'd0;
        end else if (bus.i_flush) begin
            m_v <= 1'b0;
        end else if (bus.i_valid && exp_ready) begin
            m_v <= 1'b1; m_pc <= bus.i_pc; m_rs1 <= bus.i_rs1; m_rs2 <= bus.i_rs2;
            m_rd <= bus.i_rd; m_ctrl <= bus.i_ctrl;
        end else if (bus.i_ready && exp_valid) begin
            m_v <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("cmp_valid", {31'd0, bus.o_valid}, {31'd0, exp_valid});
        chk("cmp_ready", {31'd0, bus.o_ready}, {31'd0, exp_ready});
        chk("cmp_rs_valid", {31'd0, bus.o_rs_valid}, {31'd0, bus.i_valid & exp_ready});
        if (bus.o_rs_valid) begin
            chk("cmp_rs1", {27'd0, bus.o_rs1}, {27'd0, bus.i_rs1});
            chk("cmp_rs2", {27'd0, bus.o_rs2}, {27'd0, bus.i_rs2});
        end
        if (rst) begin
            chk("cmp_rst_pc", bus.o_pc, 32'd0);
            chk("cmp_rst_op1", bus.o_op1, 32'd0);
            chk("cmp_rst_op2", bus.o_op2, 32'd0);
        end
        if (exp_valid) begin
            chk("cmp_pc", bus.o_pc, m_pc);
            chk("cmp_rd", {27'd0, bus.o_rd}, {27'd0, m_rd});
            chk("cmp_ctrl", {16'd0, bus.o_ctrl}, {16'd0, m_ctrl});
            chk("cmp_op1", bus.o_op1, want_op(m_rs1));
            chk("cmp_op2", bus.o_op2, want_op(m_rs2));
        end
    end

    task automatic idle();
        bus.i_flush = 0; bus.i_valid = 0; bus.i_pc = 0; bus.i_rs1 = 0; bus.i_rs2 = 0;
        bus.i_rd = 0; bus.i_ctrl = 0; bus.i_ex_valid = 0; bus.i_ex_load = 0;
        bus.i_ex_rd = 0; bus.i_ex_data = 0; bus.i_wb_write = 0; bus.i_wb_rd = 0;
        bus.i_wb_data = 0; bus.i_ready = 1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd);
        bus.i_valid = 1; bus.i_pc = pc; bus.i_rs1 = rs1; bus.i_rs2 = rs2; bus.i_rd = rd;
        bus.i_ctrl = pc[15:0] ^ 16'hA5A5;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        bus.i_wb_write = 1; bus.i_wb_rd = rd; bus.i_wb_data = data;
    endtask

    initial begin
        idle();
        tick(); tick(); look();
        chk("reset_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("reset_ready", {31'd0, bus.o_ready}, 32'd1);
        chk("reset_rs_valid", {31'd0, bus.o_rs_valid}, 32'd0);
        chk("reset_op1", bus.o_op1, 32'd0);
        tick(); rst = 0;

        tick(); wb(1, 32'd5);
        tick(); wb(2, 32'd7);
        tick(); wb(3, 32'h33);
        tick(); wb(4, 32'h44);

        // basic fetch
        tick(); idle(); issue(32'h100, 1, 2, 6); look();
        chk("t1_rs_valid", {31'd0, bus.o_rs_valid}, 32'd1);
        tick(); idle(); look();
        chk("t1_valid", {31'd0, bus.o_valid}, 32'd1);
        chk("t1_op1", bus.o_op1, 32'd5);
        chk("t1_op2", bus.o_op2, 32'd7);
        chk("t1_pc", bus.o_pc, 32'h100);
        chk("t1_rs_valid_once", {31'd0, bus.o_rs_valid}, 32'd0);

        // EX non-load producer of rs1
        tick(); idle(); issue(32'h104, 3, 0, 8);
        tick(); idle(); bus.i_ex_valid = 1; bus.i_ex_rd = 3; bus.i_ex_data = 32'h55; look();
`ifdef RV_OPFETCH_FWD_EX_EN
        chk("t2_valid", {31'd0, bus.o_valid}, 32'd1);
        chk("t2_op1", bus.o_op1, 32'h55);
`else
        chk("t2_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("t2_ready", {31'd0, bus.o_ready}, 32'd0);
`endif
        tick(); idle(); wb(3, 32'h55); look();
`ifndef RV_OPFETCH_FWD_EX_EN
        chk("t2_valid_wb", {31'd0, bus.o_valid}, 32'd1);
        chk("t2_op1_wb", bus.o_op1, 32'h55);
`endif

        // load-use stall
        tick(); idle(); issue(32'h108, 0, 4, 9);
        tick(); idle(); bus.i_ex_valid = 1; bus.i_ex_load = 1; bus.i_ex_rd = 4; look();
        chk("t3_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("t3_ready", {31'd0, bus.o_ready}, 32'd0);
        tick(); idle(); wb(4, 32'hAA); look();
        chk("t3_valid_wb", {31'd0, bus.o_valid}, 32'd1);
        chk("t3_op2", bus.o_op2, 32'hAA);
        chk("t3_op1_x0", bus.o_op1, 32'd0);

        // write in cycle t-1, stale regfile data in cycle t
        tick(); idle(); wb(5, 32'h11); issue(32'h10C, 5, 5, 11);
        tick(); idle(); look();
        chk("t4_op1", bus.o_op1, 32'h11);
        chk("t4_op2", bus.o_op2, 32'h11);

        // stall with a WB write to a held source
        tick(); idle(); issue(32'h110, 1, 2, 7);
        tick(); idle(); bus.i_ready = 0; wb(1, 32'd9); issue(32'h114, 3, 4, 10); look();
        chk("t5_op1_wb", bus.o_op1, 32'd9);
        chk("t5_rs_valid", {31'd0, bus.o_rs_valid}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick(); bus.i_wb_write = 0; look();
            chk("t5_pc_hold", bus.o_pc, 32'h110);
            chk("t5_op1_hold", bus.o_op1, 32'd9);
            chk("t5_ready_hold", {31'd0, bus.o_ready}, 32'd0);
        end
        tick(); bus.i_ready = 1; look();
        chk("t5_swap_rs_valid", {31'd0, bus.o_rs_valid}, 32'd1);
        chk("t5_swap_pc", bus.o_pc, 32'h110);
        tick(); idle(); look();
        chk("t5_next_pc", bus.o_pc, 32'h114);
        chk("t5_next_op1", bus.o_op1, 32'h55);
        chk("t5_next_op2", bus.o_op2, 32'hAA);

        // flush
        tick(); idle(); issue(32'h118, 2, 2, 12);
        tick(); idle(); bus.i_flush = 1; issue(32'h11C, 1, 1, 13); look();
        chk("t6_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("t6_ready", {31'd0, bus.o_ready}, 32'd0);
        chk("t6_rs_valid", {31'd0, bus.o_rs_valid}, 32'd0);
        tick(); idle(); look();
        chk("t6_empty", {31'd0, bus.o_valid}, 32'd0);

        // x0 write never forwarded
        tick(); idle(); issue(32'h120, 0, 1, 14);
        tick(); idle(); wb(0, 32'hFF); look();
        chk("t6_x0_op1", bus.o_op1, 32'd0);
        chk("t6_x0_op2", bus.o_op2, 32'd9);

        // reset mid-operation
        tick(); idle(); issue(32'h124, 1, 2, 15);
        tick(); idle(); bus.i_ready = 0; look();
        chk("t7_valid_pre", {31'd0, bus.o_valid}, 32'd1);
        rst = 1; #1;
        chk("t7_valid_rst", {31'd0, bus.o_valid}, 32'd0);
        chk("t7_pc_rst", bus.o_pc, 32'd0);
        tick(); rst = 0; idle(); look();
        chk("t7_valid_after", {31'd0, bus.o_valid}, 32'd0);
        tick(); look();
        chk("t7_valid_after2", {31'd0, bus.o_valid}, 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
